// File: rtl/arbitro_rr.sv
// arbitro_rr: routes words from N_IN input FIFOs to N_OUT output FIFOs by destination field
// Ports: clk; reset (async, active-low); emptyFIFO[N_IN] input empty flags;
//        almost_fullFIFO[N_OUT] output almost-full flags; data_in[N_IN*DATA_W] input read data;
//        pop[N_IN] one-hot input read strobe; push[N_OUT] one-hot output write strobe;
//        data_out[DATA_W] write data shared by all outputs; state[2] debug (0 IDLE, 1 ACTIVE, 2 STALL).
// Build option: define ARB_RR_EN for round-robin selection; otherwise lowest non-empty index wins.
module arbitro_rr #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 4,
    parameter int DATA_W = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_IN-1:0]          emptyFIFO,
    input  logic [N_OUT-1:0]         almost_fullFIFO,
    input  logic [N_IN*DATA_W-1:0]   data_in,
    output logic [N_IN-1:0]          pop,
    output logic [N_OUT-1:0]         push,
    output logic [DATA_W-1:0]        data_out,
    output logic [1:0]               state
);
    localparam int DEST_W = $clog2(N_OUT);
    localparam int SEL_W  = $clog2(N_IN);

    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, STALL = 2'd2} state_t;

    logic [N_IN-1:0]   req;
    logic              stall, any_req, grant;
    logic [SEL_W-1:0]  g;
    logic              s1_valid_q;
    logic [SEL_W-1:0]  s1_sel_q;
    logic [DATA_W-1:0] word, data_out_q, data_out_d;
    logic [DEST_W-1:0] dest;
    logic [N_OUT-1:0]  push_q, push_d;
    state_t            state_q, state_d;

    assign req     = ~emptyFIFO;
    assign stall   = |almost_fullFIFO;
    assign any_req = |req;
    assign grant   = !stall && any_req;

`ifdef ARB_RR_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] lo, hi;
    logic             hi_f;

    // Downward scan leaves the lowest match: hi is the first request at or after ptr,
    // lo the first overall, used when nothing at or after ptr is pending (wrap).
    always_comb begin
        lo   = '0;
        hi   = '0;
        hi_f = 1'b0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (req[i]) lo = SEL_W'(i);
            if (req[i] && i >= int'(ptr_q)) begin
                hi   = SEL_W'(i);
                hi_f = 1'b1;
            end
        end
        g     = hi_f ? hi : lo;
        ptr_d = grant ? ((g == SEL_W'(N_IN - 1)) ? '0 : g + 1'b1) : ptr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    always_comb begin
        g = '0;
        for (int i = N_IN - 1; i >= 0; i--)
            if (req[i]) g = SEL_W'(i);
    end
`endif

    assign pop = grant ? ({{(N_IN-1){1'b0}}, 1'b1} << g) : '0;

    // Input FIFOs have registered reads, so the popped word is on its slice one cycle later.
    assign word       = data_in[s1_sel_q*DATA_W +: DATA_W];
    assign dest       = word[DATA_W-1 -: DEST_W];
    assign push_d     = s1_valid_q ? ({{(N_OUT-1){1'b0}}, 1'b1} << dest) : '0;
    assign data_out_d = s1_valid_q ? word : data_out_q;

    always_comb begin
        state_d = IDLE;
        state_d = (stall && any_req) ? STALL
                : (grant || s1_valid_q || |push_q) ? ACTIVE : IDLE;
    end

    // In-flight words drain regardless of almost_full; only new pops are held back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_sel_q   <= '0;
            data_out_q <= '0;
            push_q     <= '0;
            state_q    <= IDLE;
        end else begin
            s1_valid_q <= grant;
            s1_sel_q   <= grant ? g : s1_sel_q;
            data_out_q <= data_out_d;
            push_q     <= push_d;
            state_q    <= state_d;
        end
    end

    assign push     = push_q;
    assign data_out = data_out_q;
    assign state    = state_q;
endmodule

// File: tb/tb_arbitro_rr.sv
// tb_arbitro_rr: directed self-checking bench for arbitro_rr (default and 8-in/2-out instances)
module tb_arbitro_rr;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  a_empty, a_af, a_pop, a_push;
    logic [23:0] a_din;
    logic [5:0]  a_dout;
    logic [1:0]  a_state;

    logic [7:0]  b_empty, b_pop;
    logic [1:0]  b_af, b_push, b_state;
    logic [63:0] b_din = '0;
    logic [7:0]  b_dout;
    logic        b_en;
    int          b_cnt = 0;

    int pass_cnt = 0;
    int total = 0;
    logic [3:0] ep;
    logic [5:0] w;

    always #5 clk = ~clk;

    arbitro_rr dut_a (
        .clk(clk), .reset(reset), .emptyFIFO(a_empty), .almost_fullFIFO(a_af),
        .data_in(a_din), .pop(a_pop), .push(a_push), .data_out(a_dout), .state(a_state)
    );

    arbitro_rr #(.N_IN(8), .N_OUT(2), .DATA_W(8)) dut_b (
        .clk(clk), .reset(reset), .emptyFIFO(b_empty), .almost_fullFIFO(b_af),
        .data_in(b_din), .pop(b_pop), .push(b_push), .data_out(b_dout), .state(b_state)
    );

    function automatic logic [7:0] bword(int k);
        bword = {k[0], 7'(k + 1)};
    endfunction

    // Registered-read FIFO on input 7 of the wide instance, holding 8 words.
    assign b_empty = (b_en && b_cnt < 8) ? 8'h7F : 8'hFF;
    always @(posedge clk)
        if (b_pop[7] && b_cnt < 8) begin
            b_din[56 +: 8] <= bword(b_cnt);
            b_cnt <= b_cnt + 1;
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; a_empty = 4'hF; a_af = 4'h0; a_din = '0; b_af = 2'b00; b_en = 1'b0;
        cyc(); cyc();
        chk("rst_pop", a_pop, 4'h0);
        chk("rst_push", a_push, 4'h0);
        chk("rst_dout", a_dout, 6'h00);
        chk("rst_state", a_state, 2'd0);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("idle_pop", a_pop, 4'h0);
            chk("idle_push", a_push, 4'h0);
            chk("idle_state", a_state, 2'd0);
        end
        chk("idle_dout", a_dout, 6'h00);

        // Single word on input 2, destination 2.
        a_din[12 +: 6] = 6'b100101;
        a_empty = 4'b1011; #1;
        chk("t2_pop", a_pop, 4'b0100);
        cyc(); a_empty = 4'hF; #1;
        chk("t2_nopop", a_pop, 4'h0);
        chk("t2_push_t1", a_push, 4'h0);
        chk("t2_state", a_state, 2'd1);
        cyc();
        chk("t2_push", a_push, 4'b0100);
        chk("t2_dout", a_dout, 6'b100101);
        cyc();
        chk("t2_push_off", a_push, 4'h0);
        chk("t2_dout_hold", a_dout, 6'b100101);

        // Clear the pointer, then all inputs busy; slice i carries destination i.
        reset = 1'b0; cyc(); reset = 1'b1;
        for (int i = 0; i < 4; i++) a_din[i*6 +: 6] = {2'(i), 4'(i + 8)};
        for (int k = 0; k < 10; k++) begin
            cyc();
            a_empty = (k < 8) ? 4'h0 : 4'hF; #1;
`ifdef ARB_RR_EN
            chk("t3_pop", a_pop, (k < 8) ? (4'b1 << (k % 4)) : 4'h0);
            if (k >= 2) begin
                chk("t3_push", a_push, 4'b1 << ((k - 2) % 4));
                w = {2'((k - 2) % 4), 4'(((k - 2) % 4) + 8)};
                chk("t3_dout", a_dout, w);
            end
`else
            chk("t3_pop", a_pop, (k < 8) ? 4'b0001 : 4'h0);
            if (k >= 2) begin
                chk("t3_push", a_push, 4'b0001);
                chk("t3_dout", a_dout, 6'b001000);
            end
`endif
        end

        // Backpressure with inputs 0 and 1 pending.
        cyc(); a_empty = 4'b1100; #1;
        chk("t4_pop0", a_pop, 4'b0001);
        cyc();
`ifdef ARB_RR_EN
        ep = 4'b0010;
`else
        ep = 4'b0001;
`endif
        chk("t4_pop1", a_pop, ep);
        cyc(); a_af = 4'b0010; #1;
        chk("t4_stall_pop", a_pop, 4'h0);
        chk("t4_flight0", a_push, 4'b0001);
        cyc();
        chk("t4_stall_pop2", a_pop, 4'h0);
        chk("t4_flight1", a_push, ep);
        chk("t4_state", a_state, 2'd2);
        cyc();
        chk("t4_drained", a_push, 4'h0);
        chk("t4_state2", a_state, 2'd2);
        cyc(); a_af = 4'h0; #1;
        chk("t4_resume", a_pop, 4'b0001);
        cyc(); a_empty = 4'hF; #1;
        cyc();
        chk("t4_resume_push", a_push, 4'b0001);

        // Asynchronous reset while a destination-3 word is being pushed.
        a_din[12 +: 6] = 6'b110110;
        cyc(); a_empty = 4'b1011; #1;
        chk("t5_pop", a_pop, 4'b0100);
        cyc(); a_empty = 4'hF;
        cyc();
        chk("t5_push", a_push, 4'b1000);
        #2 reset = 1'b0; #1;
        chk("t5_async_push", a_push, 4'h0);
        chk("t5_async_state", a_state, 2'd0);
        cyc(); reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t5_quiet", a_push, 4'h0);
        end
        a_empty = 4'b0110; #1;
        chk("t5_ptr0", a_pop, 4'b0001);
        cyc(); a_empty = 4'hF; #1;
        chk("t5_push_t1", a_push, 4'h0);
        cyc();
        chk("t5_push_t2", a_push, 4'b0001);

        // Wide instance: input 7 streams alternating destinations.
        cyc(); b_en = 1'b1; #1;
        for (int k = 0; k < 11; k++) begin
            chk("t6_pop", b_pop, (k < 8) ? 8'h80 : 8'h00);
            if (k >= 2 && k < 10) begin
                chk("t6_push", b_push, ((k - 2) % 2 == 1) ? 2'b10 : 2'b01);
                chk("t6_dout", b_dout, bword(k - 2));
            end else begin
                chk("t6_nopush", b_push, 2'b00);
            end
            cyc();
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
